// File: rtl/aes_key_pkg.sv
// +--------------------------------------------------------------------+
// | aes_key_pkg: shared constants, state encoding and word helpers for   |
// | the AES-128 round-key scheduler.              Revision: 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

package aes_key_pkg;

  localparam int NR = 10;
  localparam int KW = 128;
  localparam logic [3:0] ROUND_MAX = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Round constant byte for rounds 1..10; other indices never reach the XOR.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] b;
    case (r)
      4'd1:    b = 8'h01;
      4'd2:    b = 8'h02;
      4'd3:    b = 8'h04;
      4'd4:    b = 8'h08;
      4'd5:    b = 8'h10;
      4'd6:    b = 8'h20;
      4'd7:    b = 8'h40;
      4'd8:    b = 8'h80;
      4'd9:    b = 8'h1b;
      4'd10:   b = 8'h36;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/inv_key_sched_key_step.sv
// +--------------------------------------------------------------------+
// | key_step: one combinational AES-128 key-expansion step, backwards    |
// | (dir=1) or forwards (dir=0), sharing a single SubWord.  Rev: 1.0     |
// +--------------------------------------------------------------------+
`default_nettype none

module key_step
  import aes_key_pkg::*;
(
  input  logic [KW-1:0] key_i,
  input  logic [3:0]    round_i,
  input  logic          dir_i,
  output logic [KW-1:0] key_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] p3;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] mix;
  logic [7:0]  rc;

  assign k0 = key_i[127:96];
  assign k1 = key_i[95:64];
  assign k2 = key_i[63:32];
  assign k3 = key_i[31:0];

  // Backwards, the word fed to SubWord is the recovered last word of the previous round.
  assign p3     = k3 ^ k2;
  assign sub_in = rot_word(dir_i ? p3 : k3);

  generate
    for (genvar i = 0; i < 4; i++) begin : g_sbox
      assign sub_out[8*i +: 8] = SBOX[sub_in[8*i +: 8]];
    end
  endgenerate

  assign rc  = dir_i ? rcon(round_i) : rcon(round_i + 4'd1);
  assign mix = k0 ^ sub_out ^ {rc, 24'h000000};

  always_comb begin
    key_o = key_i;
    if (dir_i) begin
      key_o = {mix, k1 ^ k0, k2 ^ k1, p3};
    end else begin
      key_o[127:96] = mix;
      key_o[95:64]  = mix ^ k1;
      key_o[63:32]  = mix ^ k1 ^ k2;
      key_o[31:0]   = mix ^ k1 ^ k2 ^ k3;
    end
  end

endmodule

`default_nettype wire

// File: rtl/inv_key_sched.sv
// +--------------------------------------------------------------------+
// | inv_key_sched: streams AES-128 round keys 10..0 from the final key;  |
// | INV_KEY_SCHED_BIDIR_EN adds a dir port for 0..10.     Rev: 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

module inv_key_sched
  import aes_key_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
`ifdef INV_KEY_SCHED_BIDIR_EN
  input  logic          dir,
`endif
  input  logic [KW-1:0] key_in,
  output logic          busy,
  output logic          rk_valid,
  input  logic          rk_ready,
  output logic [KW-1:0] rk,
  output logic [3:0]    rk_round,
  output logic          done
);

  state_t        state_q, state_d;
  logic [KW-1:0] key_q, key_d;
  logic [3:0]    round_q, round_d;
  logic [KW-1:0] step_key;
  logic          dir_run;
  logic          dir_start;
  logic [3:0]    last_round;

`ifdef INV_KEY_SCHED_BIDIR_EN
  logic dir_q, dir_d;

  assign dir_start = dir;
  assign dir_run   = dir_q;

  always_comb begin
    dir_d = dir_q;
    if (state_q == ST_IDLE && start) dir_d = dir;
  end

  always_ff @(posedge clk) begin
    if (reset) dir_q <= 1'b1;
    else       dir_q <= dir_d;
  end
`else
  assign dir_start = 1'b1;
  assign dir_run   = 1'b1;
`endif

  assign last_round = dir_run ? 4'd0 : ROUND_MAX;

  key_step u_key_step (
    .key_i   (key_q),
    .round_i (round_q),
    .dir_i   (dir_run),
    .key_o   (step_key)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = dir_start ? ROUND_MAX : 4'd0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rk_ready) begin
          if (round_q == last_round) begin
            state_d = ST_FIN;
          end else begin
            key_d   = step_key;
            round_d = dir_run ? round_q - 4'd1 : round_q + 4'd1;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign busy     = (state_q == ST_EMIT);
  assign rk_valid = (state_q == ST_EMIT);
  assign done     = (state_q == ST_FIN);
  assign rk       = key_q;
  assign rk_round = round_q;

endmodule

`default_nettype wire

// File: tb/tb_inv_key_sched.sv
// +--------------------------------------------------------------------+
// | tb_inv_key_sched: directed self-checking bench for inv_key_sched     |
// | using the FIPS-197 example key schedule.              Rev: 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_inv_key_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         done;
`ifdef INV_KEY_SCHED_BIDIR_EN
  logic         dir;
`endif

  int checks = 0;
  int errors = 0;

  logic [127:0] K [11];

  always #5 clk = ~clk;

  inv_key_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef INV_KEY_SCHED_BIDIR_EN
    .dir      (dir),
`endif
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_round (rk_round),
    .done     (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    step();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rk_ready = 1'b1; key_in = '0;
    step(); step();
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rk_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (rk !== 128'h0) begin errors++; $display("FAIL reset_rk got %h exp 0", rk); end
    checks++; if (rk_round !== 4'd0) begin errors++; $display("FAIL reset_round got %0d exp 0", rk_round); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_fips();
    rk_ready = 1'b1;
    begin_run(K[10]);
    for (int r = 10; r >= 0; r--) begin
      checks++; if (rk !== K[r]) begin errors++; $display("FAIL fips_rk r%0d got %h exp %h", r, rk, K[r]); end
      checks++; if (rk_round !== 4'(r)) begin errors++; $display("FAIL fips_round got %0d exp %0d", rk_round, r); end
      checks++; if (rk_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL fips_valid r%0d got %b%b exp 11", r, rk_valid, busy); end
      step();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL fips_fin got done=%b busy=%b valid=%b exp 1 0 0", done, busy, rk_valid); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL fips_done_width got %b exp 0", done); end
  endtask

  task automatic test_backpressure();
    rk_ready = 1'b1;
    begin_run(K[10]);
    step();
    rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (rk !== K[9] || rk_round !== 4'd9 || rk_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold c%0d got %h r%0d v%b exp %h r9 v1", i, rk, rk_round, rk_valid, K[9]); end
    end
    rk_ready = 1'b1;
    for (int r = 8; r >= 0; r--) begin
      step();
      checks++; if (rk !== K[r] || rk_round !== 4'(r)) begin
        errors++; $display("FAIL bp_resume got %h r%0d exp %h r%0d", rk, rk_round, K[r], r); end
    end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %b exp 1", done); end
    step();
  endtask

  task automatic test_start_midrun();
    int ndone;
    rk_ready = 1'b1;
    begin_run(K[10]);
    for (int i = 0; i < 5; i++) step();
    checks++; if (rk_round !== 4'd5) begin errors++; $display("FAIL mid_at5 got %0d exp 5", rk_round); end
    start = 1'b1; key_in = K[0];
    step();
    start = 1'b0;
    for (int r = 4; r >= 0; r--) begin
      checks++; if (rk !== K[r] || rk_round !== 4'(r)) begin
        errors++; $display("FAIL mid_seq got %h r%0d exp %h r%0d", rk, rk_round, K[r], r); end
      step();
    end
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) ndone++;
      step();
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL mid_done_count got %0d exp 1", ndone); end
  endtask

  task automatic test_reset_midrun();
    int ndone;
    rk_ready = 1'b1;
    begin_run(K[10]);
    for (int i = 0; i < 6; i++) step();
    checks++; if (rk_round !== 4'd4) begin errors++; $display("FAIL rst_at4 got %0d exp 4", rk_round); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (rk_valid !== 1'b0 || busy !== 1'b0 || rk !== 128'h0 || rk_round !== 4'd0) begin
      errors++; $display("FAIL rst_mid got v%b b%b %h r%0d exp 0 0 0 r0", rk_valid, busy, rk, rk_round); end
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) ndone++;
      step();
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rst_no_done got %0d exp 0", ndone); end
    begin_run(K[10]);
    checks++; if (rk !== K[10] || rk_round !== 4'd10) begin
      errors++; $display("FAIL rst_restart10 got %h r%0d exp %h r10", rk, rk_round, K[10]); end
    step();
    checks++; if (rk !== K[9] || rk_round !== 4'd9) begin
      errors++; $display("FAIL rst_restart9 got %h r%0d exp %h r9", rk, rk_round, K[9]); end
    for (int i = 0; i < 11; i++) step();
  endtask

  task automatic test_back_to_back();
    rk_ready = 1'b1;
    begin_run(K[10]);
    for (int i = 0; i < 11; i++) step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_fin got %b exp 1", done); end
    start = 1'b1; key_in = K[5];
    step();
    checks++; if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_fin_start got v%b b%b exp 0 0", rk_valid, busy); end
    step();
    start = 1'b0;
    checks++; if (rk_valid !== 1'b1 || rk_round !== 4'd10 || rk !== K[5]) begin
      errors++; $display("FAIL b2b_accept got v%b r%0d %h exp 1 r10 %h", rk_valid, rk_round, rk, K[5]); end
    for (int i = 0; i < 12; i++) step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got b%b d%b exp 0 0", busy, done); end
  endtask

`ifdef INV_KEY_SCHED_BIDIR_EN
  task automatic test_forward();
    rk_ready = 1'b1;
    dir = 1'b0;
    begin_run(K[0]);
    dir = 1'b1;
    for (int r = 0; r <= 10; r++) begin
      checks++; if (rk !== K[r] || rk_round !== 4'(r)) begin
        errors++; $display("FAIL fwd_rk got %h r%0d exp %h r%0d", rk, rk_round, K[r], r); end
      step();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL fwd_done got %b exp 1", done); end
    step();
  endtask
`endif

  initial begin
    K[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    K[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    K[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    K[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    K[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    K[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    K[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    K[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    K[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    K[9]  = 128'hac7766f319fadc2128d12941575c006e;
    K[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef INV_KEY_SCHED_BIDIR_EN
    dir = 1'b1;
`endif
    test_reset();
    test_fips();
    test_backpressure();
    test_start_midrun();
    test_reset_midrun();
    test_back_to_back();
`ifdef INV_KEY_SCHED_BIDIR_EN
    test_forward();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
